// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode/funct constants, the NOP word,
// the decode FSM state encoding and small instruction-class helpers used by
// both the hazard detector and the redirect logic.
package mips_pkg;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FN_JR = 6'h08;

  // Canonical bubble word (sll $0,$0,0).
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Decode FSM state.
  typedef enum logic {
    ST_RUN,
    ST_STALL
  } state_e;

  // Instruction classes that matter to the front end.
  typedef enum logic [2:0] {
    ClOther,
    ClRtype,
    ClBeq,
    ClBne,
    ClJ,
    ClJal,
    ClJr
  } instr_class_e;

  function automatic instr_class_e decode_class(input logic [31:0] instr);
    instr_class_e cls;
    cls = ClOther;
    case (instr[31:26])
      OP_RTYPE: cls = (instr[5:0] == FN_JR) ? ClJr : ClRtype;
      OP_BEQ:   cls = ClBeq;
      OP_BNE:   cls = ClBne;
      OP_J:     cls = ClJ;
      OP_JAL:   cls = ClJal;
      default:  cls = ClOther;
    endcase
    return cls;
  endfunction

  // Every class reads rs except the absolute jumps.
  function automatic logic uses_rs(input instr_class_e cls);
    return !(cls == ClJ || cls == ClJal);
  endfunction

  // rt is a source for R-type ALU ops, the two compares and stores.
  function automatic logic uses_rt(input instr_class_e cls, input logic [5:0] opcode);
    return (cls == ClRtype) || (cls == ClBeq) || (cls == ClBne) || (opcode == OP_SW);
  endfunction

  // Instructions whose operands are consumed in decode.
  function automatic logic resolves_in_id(input instr_class_e cls);
    return (cls == ClBeq) || (cls == ClBne) || (cls == ClJr);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detector for the decode stage.
//   instr_i          : instruction held in IF/ID
//   idex_mem_read_i  : instruction in EX is a load
//   idex_reg_write_i : instruction in EX writes a register
//   idex_dest_reg_i  : destination register of the instruction in EX
//   hazard_o         : decode must stall this cycle
//   depth_o          : total number of stall cycles required (1 or 2)
module hazard_detect
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        idex_mem_read_i,
  input  logic        idex_reg_write_i,
  input  logic [4:0]  idex_dest_reg_i,
  output logic        hazard_o,
  output logic [1:0]  depth_o
);

  instr_class_e cls;
  logic [4:0]   rs;
  logic [4:0]   rt;
  logic         dest_live;
  logic         rs_match;
  logic         rt_match;
  logic         load_use;
  logic         branch_hz;
  logic         unused_instr_bits;

  assign cls = decode_class(instr_i);
  assign rs  = instr_i[25:21];
  assign rt  = instr_i[20:16];

  // Immediate/shamt bits never influence hazards.
  assign unused_instr_bits = ^instr_i[15:6];

  always_comb begin
    // $0 is never a real producer.
    dest_live = (idex_dest_reg_i != 5'd0);
    rs_match  = uses_rs(cls) && (rs == idex_dest_reg_i);
    rt_match  = uses_rt(cls, instr_i[31:26]) && (rt == idex_dest_reg_i);

    load_use  = idex_mem_read_i && dest_live && (rs_match || rt_match);
    branch_hz = resolves_in_id(cls) && idex_reg_write_i && dest_live &&
                (rs_match || rt_match);

    hazard_o = load_use || branch_hz;
    // A branch waiting on a load needs the value past MEM: two cycles.
    depth_o  = (branch_hz && idex_mem_read_i) ? 2'd2 : 2'd1;
  end

endmodule

// File: rtl/id_fetch_control.sv
// Decode-side front-end control. Holds the IF/ID pipeline register, resolves
// branches and jumps in decode, stalls on load-use and branch-operand hazards
// and drives the fetch PC controls.
//   Clk, Reset         : clock and synchronous active-high reset
//   Instruction        : fetched instruction for the current PC
//   PCPlus4_in         : PC+4 of that instruction
//   RsData / RtData    : register-file reads of IF/ID rs / rt
//   IDEX_MemRead       : EX instruction is a load
//   IDEX_RegWrite      : EX instruction writes a register
//   IDEX_DestReg       : EX destination register
//   PCWrite            : fetch PC update enable
//   PCSrc              : 1 selects PC_target in fetch, 0 selects PC+4
//   PC_target          : redirect address (0 when not redirecting)
//   IFID_Instruction   : registered instruction presented to decode
//   IFID_PCPlus4       : registered PC+4 presented to decode
//   Bubble             : zero all ID/EX control this cycle
module id_fetch_control
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCPlus4_in,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_RegWrite,
  input  logic [4:0]  IDEX_DestReg,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [31:0] PC_target,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        Bubble
);

  state_e       state_q, state_d;
  logic [1:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;

  logic         hazard;
  logic [1:0]   depth;
  instr_class_e cls;
  logic [31:0]  br_off;
  logic [31:0]  br_tgt;
  logic [31:0]  jmp_tgt;
  logic         taken;
  logic [31:0]  redirect_tgt;

  hazard_detect u_hazard_detect (
    .instr_i          (ifid_instr_q),
    .idex_mem_read_i  (IDEX_MemRead),
    .idex_reg_write_i (IDEX_RegWrite),
    .idex_dest_reg_i  (IDEX_DestReg),
    .hazard_o         (hazard),
    .depth_o          (depth)
  );

  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pc4_q;

  // Redirect resolution from the IF/ID contents and same-cycle operands.
  always_comb begin
    cls     = decode_class(ifid_instr_q);
    br_off  = {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
    br_tgt  = ifid_pc4_q + br_off;
    jmp_tgt = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};

    taken        = 1'b0;
    redirect_tgt = 32'd0;
    case (cls)
      ClBeq: begin
        taken        = (RsData == RtData);
        redirect_tgt = br_tgt;
      end
      ClBne: begin
        taken        = (RsData != RtData);
        redirect_tgt = br_tgt;
      end
      ClJ, ClJal: begin
        taken        = 1'b1;
        redirect_tgt = jmp_tgt;
      end
      ClJr: begin
        taken        = 1'b1;
        redirect_tgt = RsData;
      end
      default: begin
        taken        = 1'b0;
        redirect_tgt = 32'd0;
      end
    endcase
  end

  // Next-state and fetch-control outputs.
  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    PCWrite      = 1'b1;
    PCSrc        = 1'b0;
    PC_target    = 32'd0;
    Bubble       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          PCWrite = 1'b0;
          Bubble  = 1'b1;
          // The detect cycle is itself the first stall cycle, so the counter
          // is loaded with the depth already decremented once.
          stall_cnt_d = depth - 2'd1;
          state_d     = (depth > 2'd1) ? ST_STALL : ST_RUN;
        end else if (taken) begin
          PCSrc        = 1'b1;
          PC_target    = redirect_tgt;
          // Squash the wrong-path instruction fetched alongside the branch.
          ifid_instr_d = NOP_WORD;
          ifid_pc4_d   = PCPlus4_in;
        end else begin
          ifid_instr_d = Instruction;
          ifid_pc4_d   = PCPlus4_in;
        end
      end
      ST_STALL: begin
        PCWrite = 1'b0;
        Bubble  = 1'b1;
        if (stall_cnt_q <= 2'd1) begin
          stall_cnt_d = 2'd0;
          state_d     = ST_RUN;
        end else begin
          stall_cnt_d = stall_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        stall_cnt_d = 2'd0;
      end
    endcase

    // Reset overrides any stall or redirect in flight.
    if (Reset) begin
      PCWrite   = 1'b1;
      PCSrc     = 1'b0;
      PC_target = 32'd0;
      Bubble    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_RUN;
      stall_cnt_q  <= 2'd0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

endmodule

// File: tb/tb_id_fetch_control.sv
// Self-checking bench for id_fetch_control. Each cycle drives fetch and EX
// inputs, pushes the hand-derived expected outputs to a scoreboard and pops
// them for comparison at the falling edge.
module tb_id_fetch_control;

  localparam logic [31:0] NOPW  = 32'h0000_0000;
  localparam logic [31:0] ADD   = 32'h010A_4820; // add  $9,$8,$10
  localparam logic [31:0] OR1   = 32'h014B_6020; // add  $12,$10,$11
  localparam logic [31:0] LUI   = 32'h3C01_0001; // lui  $1,1
  localparam logic [31:0] BEQ0  = 32'h1085_0000; // beq  $4,$5,0
  localparam logic [31:0] BEQM4 = 32'h1085_FFFC; // beq  $4,$5,-4
  localparam logic [31:0] JR31  = 32'h03E0_0008; // jr   $31
  localparam logic [31:0] BNE   = 32'h1485_0010; // bne  $4,$5,16
  localparam logic [31:0] ADDI  = 32'h2001_0005; // addi $1,$0,5
  localparam logic [31:0] JMP   = 32'h0810_0040; // j    0x00400100

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, pc_plus4_in, rs_data, rt_data;
  logic        idex_mem_read, idex_reg_write;
  logic [4:0]  idex_dest_reg;
  logic        pc_write, pc_src, bubble;
  logic [31:0] pc_target, ifid_instruction, ifid_pc_plus4;

  always #5 clk = ~clk;

  id_fetch_control #(.NOP_WORD(32'h0000_0000)) dut (
    .Clk              (clk),
    .Reset            (reset),
    .Instruction      (instruction),
    .PCPlus4_in       (pc_plus4_in),
    .RsData           (rs_data),
    .RtData           (rt_data),
    .IDEX_MemRead     (idex_mem_read),
    .IDEX_RegWrite    (idex_reg_write),
    .IDEX_DestReg     (idex_dest_reg),
    .PCWrite          (pc_write),
    .PCSrc            (pc_src),
    .PC_target        (pc_target),
    .IFID_Instruction (ifid_instruction),
    .IFID_PCPlus4     (ifid_pc_plus4),
    .Bubble           (bubble)
  );

  typedef struct {
    logic        pcw;
    logic        src;
    logic [31:0] tgt;
    logic        bub;
    logic [31:0] ifi;
    logic [31:0] ifp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   step_no = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One decode cycle: drive, push expectation, compare at negedge, advance.
  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc4,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic mr, input logic rw, input logic [4:0] dst,
                      input logic e_pcw, input logic e_src, input logic [31:0] e_tgt,
                      input logic e_bub, input logic [31:0] e_ifi, input logic [31:0] e_ifp);
    exp_t e;
    reset          = rst;
    instruction    = ins;
    pc_plus4_in    = pc4;
    rs_data        = rs;
    rt_data        = rt;
    idex_mem_read  = mr;
    idex_reg_write = rw;
    idex_dest_reg  = dst;
    e.pcw = e_pcw;
    e.src = e_src;
    e.tgt = e_tgt;
    e.bub = e_bub;
    e.ifi = e_ifi;
    e.ifp = e_ifp;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq($sformatf("s%0d_scoreboard", step_no), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq($sformatf("s%0d_pcwrite", step_no), {31'd0, pc_write}, {31'd0, e.pcw});
      check_eq($sformatf("s%0d_pcsrc", step_no), {31'd0, pc_src}, {31'd0, e.src});
      check_eq($sformatf("s%0d_pc_target", step_no), pc_target, e.tgt);
      check_eq($sformatf("s%0d_bubble", step_no), {31'd0, bubble}, {31'd0, e.bub});
      check_eq($sformatf("s%0d_ifid_instr", step_no), ifid_instruction, e.ifi);
      check_eq($sformatf("s%0d_ifid_pc4", step_no), ifid_pc_plus4, e.ifp);
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    instruction    = 32'd0;
    pc_plus4_in    = 32'd0;
    rs_data        = 32'd0;
    rt_data        = 32'd0;
    idex_mem_read  = 1'b0;
    idex_reg_write = 1'b0;
    idex_dest_reg  = 5'd0;
    repeat (2) @(posedge clk);
    #1;

    //   rst   instr  pc4            rs            rt     mr rw dst  pcw src tgt bub ifid_i ifid_p
    // Reset state, add enters IF/ID.
    step(1'b0, ADD,   32'h0040_0004, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0, NOPW, 32'd0);
    // Load-use: lw $8 in EX, one stall cycle, IF/ID holds.
    step(1'b0, OR1,   32'h0040_0008, 32'd0,        32'd0, 1, 1, 5'd8, 0, 0, 32'd0, 1,
         ADD, 32'h0040_0004);
    step(1'b0, OR1,   32'h0040_0008, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         ADD, 32'h0040_0004);
    step(1'b0, BEQ0,  32'h0040_000C, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         OR1, 32'h0040_0008);
    // Load-to-branch: two stall cycles, then beq resolves taken.
    step(1'b0, LUI,   32'h0040_0010, 32'd1,        32'd2, 1, 1, 5'd4, 0, 0, 32'd0, 1,
         BEQ0, 32'h0040_000C);
    step(1'b0, LUI,   32'h0040_0010, 32'd1,        32'd2, 0, 0, 5'd0, 0, 0, 32'd0, 1,
         BEQ0, 32'h0040_000C);
    step(1'b0, LUI,   32'h0040_0010, 32'd3,        32'd3, 0, 0, 5'd0, 1, 1, 32'h0040_000C, 0,
         BEQ0, 32'h0040_000C);
    // Squash NOP, then taken beq with negative offset.
    step(1'b0, BEQM4, 32'h0040_0010, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         NOPW, 32'h0040_0010);
    step(1'b0, 32'hDEAD_BEEF, 32'h0040_0014, 32'd7, 32'd7, 0, 0, 5'd0, 1, 1, 32'h0040_0000, 0,
         BEQM4, 32'h0040_0010);
    // jr.
    step(1'b0, JR31,  32'h0040_0004, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         NOPW, 32'h0040_0014);
    step(1'b0, 32'h1234_5678, 32'h0040_0008, 32'h0040_0100, 32'd0, 0, 0, 5'd0,
         1, 1, 32'h0040_0100, 0, JR31, 32'h0040_0004);
    // Not-taken bne: no squash, next instruction advances.
    step(1'b0, BNE,   32'h0040_0104, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         NOPW, 32'h0040_0008);
    step(1'b0, ADDI,  32'h0040_0108, 32'd5,        32'd5, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         BNE, 32'h0040_0104);
    // DestReg=0 load against rs=$0: no stall.
    step(1'b0, JMP,   32'h0040_010C, 32'd0,        32'd0, 1, 1, 5'd0, 1, 0, 32'd0, 0,
         ADDI, 32'h0040_0108);
    // Absolute jump.
    step(1'b0, 32'h1111_1111, 32'h0040_0110, 32'd0, 32'd0, 0, 0, 5'd0, 1, 1, 32'h0040_0100, 0,
         JMP, 32'h0040_010C);
    step(1'b0, BEQ0,  32'h0040_0104, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         NOPW, 32'h0040_0110);
    // Depth-2 stall, then Reset for two cycles aborts it.
    step(1'b0, ADD,   32'h0040_0108, 32'd1,        32'd2, 1, 1, 5'd5, 0, 0, 32'd0, 1,
         BEQ0, 32'h0040_0104);
    step(1'b1, ADD,   32'h0040_0108, 32'd1,        32'd2, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         BEQ0, 32'h0040_0104);
    step(1'b1, ADD,   32'h0040_0108, 32'd1,        32'd2, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         NOPW, 32'd0);
    step(1'b0, ADD,   32'h0040_0004, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         NOPW, 32'd0);
    step(1'b0, OR1,   32'h0040_0008, 32'd0,        32'd0, 0, 0, 5'd0, 1, 0, 32'd0, 0,
         ADD, 32'h0040_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
